// File: rtl/gbd_sram_burst_writer.sv
// gbd_sram_burst_writer
//   Copies LEN bytes from the frame buffer into cartridge SRAM at BASE, one
//   byte per bus cycle with programmable setup/pulse/hold timing. Owns the
//   cart SRAM bus while busy.
//   Optional feature macro: GBD_WRITE_CHECKSUM_EN adds the wr_sum output, a
//   16-bit running sum of the bytes written in the current transfer.
module gbd_sram_burst_writer #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OFS_W     = 10,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic              sys_clock,
  input  logic              sys_resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [OFS_W-1:0]  buf_base,
  input  logic [OFS_W:0]    length,
  output logic              busy,
  output logic              done,
  output logic              ram_writing,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_data_oe,
  output logic              ram_ncs,
  output logic              ram_nwe,
  output logic              buf_req,
  output logic [OFS_W-1:0]  buf_ofs,
`ifdef GBD_WRITE_CHECKSUM_EN
  output logic [15:0]       wr_sum,
`endif
  input  logic              buf_ready,
  input  logic [DATA_W-1:0] buf_data
);

  localparam int unsigned MAX_CYC =
    (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                            : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int unsigned CNT_W = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [OFS_W:0]   IDX_ONE     = (OFS_W+1)'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [OFS_W:0]    idx, idx_d, idx_inc;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              accept, capture;
  logic [ADDR_W-1:0] base_q;
  logic [OFS_W-1:0]  buf_base_q;
  logic [OFS_W:0]    len_q;
  logic [OFS_W-1:0]  ofs_next;
  logic              bus_on_d;

  assign idx_inc     = idx + IDX_ONE;
  assign ram_writing = busy;

  // State register and per-byte/phase counters
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state, counter and strobe decode
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    accept  = 1'b0;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (length == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (buf_req && buf_ready) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? S_DONE : S_FETCH;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Offset for the next fetch; on the accepting cycle the latched base is not yet valid
  always_comb begin
    ofs_next = (accept ? buf_base : buf_base_q) + idx_d[OFS_W-1:0];
    bus_on_d = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD);
  end

  // Registered outputs, decoded from the next state so they line up with the state register;
  // done is delayed one cycle behind DONE so that it coincides with busy falling
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      base_q      <= '0;
      buf_base_q  <= '0;
      len_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      ram_data_oe <= 1'b0;
      ram_ncs     <= 1'b1;
      ram_nwe     <= 1'b1;
      buf_req     <= 1'b0;
      buf_ofs     <= '0;
    end else begin
      if (accept) begin
        base_q     <= base_addr;
        buf_base_q <= buf_base;
        len_q      <= length;
      end
      if (capture) begin
        ram_data <= buf_data;
        ram_addr <= base_q + ADDR_W'(idx);
      end
      if (state_d == S_FETCH) begin
        buf_ofs <= ofs_next;
      end
      busy        <= (state_d != S_IDLE);
      done        <= (state == S_DONE);
      buf_req     <= (state_d == S_FETCH);
      ram_ncs     <= !bus_on_d;
      ram_data_oe <= bus_on_d;
      ram_nwe     <= (state_d != S_PULSE);
    end
  end

`ifdef GBD_WRITE_CHECKSUM_EN
  // Running sum of written bytes, accumulated as each byte enters the write pulse
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      wr_sum <= '0;
    end else if (accept) begin
      wr_sum <= '0;
    end else if (state == S_SETUP && state_d == S_PULSE) begin
      wr_sum <= wr_sum + 16'(ram_data);
    end
  end
`endif

endmodule
